// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the mccomp multi-cycle control unit: opcodes, functs,
// FSM states, instruction classes and datapath select codes.
package mc_ctrl_pkg;

  localparam int MC_STATE_W = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } iclass_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd1;
  localparam logic [1:0] SRCB_ZEXT = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: (opcode, funct) to ALU controls and
// instruction class used by the mc_ctrl FSM.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output iclass_e    iclass
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    iclass    = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        iclass = C_R;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          // Shifts take the shift amount from the shamt field, not rs.
          FN_SLL: begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; alu_src_a = 1'b1; end
          FN_JR:  iclass = C_JUMP;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:   iclass = C_JUMP;
      OP_BEQ, OP_BNE: begin iclass = C_BRANCH; alu_op = ALU_SUB; end
      OP_ADDI: begin iclass = C_IALU;  alu_src_b = SRCB_SEXT; end
      OP_ORI:  begin iclass = C_IALU;  alu_src_b = SRCB_ZEXT; alu_op = ALU_OR; end
      OP_LUI:  begin iclass = C_IALU;  alu_src_b = SRCB_ZEXT; alu_op = ALU_LUI; end
      OP_LW:   begin iclass = C_LOAD;  alu_src_b = SRCB_SEXT; end
      OP_SW:   begin iclass = C_STORE; alu_src_b = SRCB_SEXT; end
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the mccomp MIPS core (IF/ID/EXE/MEM/WB).
// Define MC_CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions instead of NOP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = MC_STATE_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         NPCOp,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  state_e     state_q;
  state_e     state_nxt;
  iclass_e    iclass;
  logic [3:0] dec_alu_op;
  logic       dec_src_a;
  logic [1:0] dec_src_b;

  mc_alu_dec u_alu_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .iclass    (iclass)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IF;
    else       state_q <= state_nxt;
  end

  assign state = STATE_W'(state_q);

  always_comb begin
    state_nxt = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = RD_RT;
    WDSel     = WD_ALU;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    ALUOp     = ALU_ADD;
    NPCOp     = NPC_PC4;
    illegal   = 1'b0;
    case (state_q)
      S_IF: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        case (iclass)
          C_JUMP: begin
            PCWrite   = 1'b1;
            state_nxt = S_IF;
            if (opcode == OP_RTYPE) begin
              NPCOp = NPC_JR;
            end else begin
              NPCOp = NPC_J;
              // jal links the already-incremented PC into $31.
              if (opcode == OP_JAL) begin
                RegWrite = 1'b1;
                RegDst   = RD_RA;
                WDSel    = WD_PC;
              end
            end
          end
          C_ILLEGAL: begin
            illegal = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_IF;
`endif
          end
          default: state_nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_src_a;
        ALUSrcB = dec_src_b;
        case (iclass)
          C_BRANCH: begin
            NPCOp     = NPC_BR;
            PCWrite   = (opcode == OP_BEQ) ? zero : ~zero;
            state_nxt = S_IF;
          end
          C_LOAD, C_STORE: state_nxt = S_MEM;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (iclass == C_STORE) begin
          MemWrite  = 1'b1;
          state_nxt = S_IF;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        state_nxt = S_IF;
        if (iclass == C_LOAD) WDSel  = WD_MDR;
        else if (iclass == C_R) RegDst = RD_RD;
      end
      S_HALT: begin
        illegal   = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; follows MC_CTRL_ILLEGAL_TRAP_EN
// to choose the expected illegal-instruction behaviour.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, ALUSrcA, illegal;
  logic [1:0] RegDst, WDSel, ALUSrcB, NPCOp;
  logic [3:0] ALUOp;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  mc_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .WDSel    (WDSel),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .NPCOp    (NPCOp),
    .state    (state),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // Field order: state pcw irw iord mw rw regdst wdsel srca srcb aluop npc illegal
  task automatic chk(input string tag, input logic [2:0] st, input logic pcw,
                     input logic irw, input logic iord, input logic mw, input logic rw,
                     input logic [1:0] rd, input logic [1:0] wd, input logic sa,
                     input logic [1:0] sb, input logic [3:0] aop, input logic [1:0] npc,
                     input logic ill);
    logic [21:0] obs, exp;
    obs = {state, PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUOp, NPCOp, illegal};
    exp = {st, pcw, irw, iord, mw, rw, rd, wd, sa, sb, aop, npc, ill};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr);
    opcode = instr[31:26];
    funct  = instr[5:0];
  endtask

  // Every fetch cycle looks identical regardless of the instruction.
  task automatic chk_if(input string tag);
    chk(tag, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0);
  endtask

  task automatic chk_id_plain(input string tag);
    chk(tag, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; opcode = 6'h0; funct = 6'h0; zero = 1'b0;
    #21;
    chk_if("reset");
    load(32'h00221820);                // add $3,$1,$2
    #1 rstn = 1'b1;
    step(); chk_id_plain("add_id");
    step(); chk("add_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk("add_wb",  3'd4, 0,0,0,0,1, 2'd1, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk_if("add_if");

    load(32'h00021080);                // sll $2,$2,2
    step(); chk_id_plain("sll_id");
    step(); chk("sll_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 4'd5, 2'd0, 0);
    step(); chk("sll_wb",  3'd4, 0,0,0,0,1, 2'd1, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk_if("sll_if");

    load(32'h3422000F);                // ori $2,$1,0xF
    step(); chk_id_plain("ori_id");
    step(); chk("ori_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd2, 4'd3, 2'd0, 0);
    step(); chk("ori_wb",  3'd4, 0,0,0,0,1, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk_if("ori_if");

    load(32'h3C021234);                // lui $2,0x1234
    step(); chk_id_plain("lui_id");
    step(); chk("lui_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd2, 4'd7, 2'd0, 0);
    step(); step(); chk_if("lui_if");

    load(32'h8C220004);                // lw $2,4($1)
    step(); chk_id_plain("lw_id");
    step(); chk("lw_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd1, 4'd0, 2'd0, 0);
    step(); chk("lw_mem", 3'd3, 0,0,1,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk("lw_wb",  3'd4, 0,0,0,0,1, 2'd0, 2'd1, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk_if("lw_if");

    load(32'hAC220004);                // sw $2,4($1)
    step(); chk_id_plain("sw_id");
    step(); chk("sw_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd1, 4'd0, 2'd0, 0);
    step(); chk("sw_mem", 3'd3, 0,0,1,1,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    step(); chk_if("sw_if");

    load(32'h10220003); zero = 1'b1;   // beq taken
    step(); chk_id_plain("beq1_id");
    step(); chk("beq1_exe", 3'd2, 1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd1, 2'd1, 0);
    step(); chk_if("beq1_if");
    zero = 1'b0;                       // beq not taken
    step(); step(); chk("beq0_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd1, 2'd1, 0);
    step();
    load(32'h14220003); zero = 1'b0;   // bne taken
    step(); step(); chk("bne0_exe", 3'd2, 1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd1, 2'd1, 0);
    step(); zero = 1'b1;               // bne not taken
    step(); step(); chk("bne1_exe", 3'd2, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd1, 2'd1, 0);
    step(); chk_if("bne1_if");

    load(32'h0C000010);                // jal 0x40
    step(); chk("jal_id", 3'd1, 1,0,0,0,1, 2'd2, 2'd2, 0, 2'd0, 4'd0, 2'd2, 0);
    step(); chk_if("jal_if");
    load(32'h03E00008);                // jr $31
    step(); chk("jr_id", 3'd1, 1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd3, 0);
    step(); chk_if("jr_if");

    load(32'hAC220004);                // sw, then reset in MEM
    step(); step(); step();
    chk("rst_sw_mem", 3'd3, 0,0,1,1,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 0);
    rstn = 1'b0;
    #1 chk_if("rst_async");
    load(32'hFC000000);                // opcode 0x3F
    #1 rstn = 1'b1;
    step(); chk("ill_id", 3'd1, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step(); chk("ill_halt", 3'd5, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 1);
    load(32'h08000010);
    step(); step();
    chk("ill_halt_hold", 3'd5, 0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd0, 1);
`else
    step(); chk_if("ill_nop_if");
    load(32'h08000010);                // j 0x40 fetched after the NOP
    step(); chk("ill_next_j", 3'd1, 1,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 2'd2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit for the mccomp MIPS core. It sequences each instruction through IF/ID/EXE/MEM/WB over one unified instruction/data memory. It drives the PC, IR, register-file, memory and mux controls consumed by the datapath. It sits directly upstream of the datapath inside mccomp and decodes the IR contents that the datapath latches under its IRWrite.

Parameters:
STATE_W, 3, width of state encoding (fixed by package; exposed for debug port width)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from ID onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXE
PCWrite  out  1  PC register load enable
IRWrite  out  1  instruction register load enable
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write enable
RegWrite  out  1  register-file write enable
RegDst  out  2  0=rt, 1=rd, 2=$31
WDSel  out  2  0=ALUOut, 1=MDR, 2=PC
ALUSrcA  out  1  0=rs, 1=shamt
ALUSrcB  out  2  0=rt, 1=sign-ext imm, 2=zero-ext imm
ALUOp  out  4  ADD=0 SUB=1 AND=2 OR=3 SLT=4 SLL=5 SRL=6 LUI=7
NPCOp  out  2  0=PC+4, 1=branch, 2=jump, 3=jr
state  out  3  current state (IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=5)
illegal  out  1  unsupported instruction seen

Behaviour:
- Supported instructions: R-type add/sub/and/or/slt/sll/srl/jr; addi, ori, lui, lw, sw, beq, bne, j, jal. Everything else is illegal.
- State is a single register, async reset to IF. All outputs are combinational from state, opcode, funct and zero.
- Reset values (state=IF): IRWrite=1, PCWrite=1, NPCOp=0, IorD=0. All other enables are 0, selects 0 and illegal 0.
- The first fetch starts on the first rising clk after rstn deasserts.
- IF: IRWrite=1, PCWrite=1, NPCOp=PC+4, IorD=0. Next state is ID.
- ID decode rules:
  - j: PCWrite=1, NPCOp=jump. Next state IF.
  - jal: PCWrite=1, NPCOp=jump, RegWrite=1, RegDst=2, WDSel=2. The PC already holds PC+4. Next state IF.
  - jr (opcode 0, funct 0x08): PCWrite=1, NPCOp=jr. Next state IF.
  - Illegal: see Optional Feature.
  - All others: next state EXE.
- EXE:
  - ALU controls are set per instruction.
  - sll/srl use ALUSrcA=1.
  - addi/lw/sw use ALUSrcB=1; ori uses ALUSrcB=2; lui uses ALUSrcB=2 with ALUOp=LUI.
  - beq/bne: ALUOp=SUB, NPCOp=branch, PCWrite=zero (beq) or ~zero (bne). Next state IF.
  - lw/sw: next state MEM. ALU-class instructions: next state WB.
- MEM: IorD=1. sw asserts MemWrite=1 and goes to IF. lw goes to WB.
- WB: RegWrite=1.
  - lw: RegDst=0, WDSel=1.
  - R-type: RegDst=1, WDSel=0.
  - I-type ALU: RegDst=0, WDSel=0.
  - Next state IF.
- Latency in cycles: j/jal/jr 2, branch 3, sw 4, R/I-ALU 4, lw 5.
- MemWrite and RegWrite are each asserted for exactly one cycle per instruction; never both in the same cycle.
- Reset mid-instruction: state goes to IF immediately (asynchronously), and any MemWrite/RegWrite drops within the same cycle.
- Writes to $0 are not filtered here; that is the register file's job.

Optional Feature:
Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct in ID sets illegal=1 and enters HALT. In HALT all enables are 0 (including PCWrite/IRWrite) and illegal stays 1. Only rstn leaves HALT.
- Undefined: an illegal instruction behaves as a NOP (ID goes to IF, no writes). illegal pulses 1 for that ID cycle only, and HALT is unreachable.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - ALUOp, NPCOp, WDSel, RegDst and ALUSrcB codes.
- One natural sub-module: mc_alu_dec, a combinational decoder from (opcode, funct) to ALUOp, ALUSrcA, ALUSrcB and instruction class (R, I-ALU, LOAD, STORE, BRANCH, JUMP, ILLEGAL).
- mc_ctrl owns the FSM and output muxing.

Test Plan:
- Reset: hold rstn=0 for 20 ns -> state=0, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0; first IR load on the first edge after release.
- add $3,$1,$2 (0x00221820) -> state sequence 0,1,2,4,0; ALUOp=0; RegWrite=1 only in WB with RegDst=1, WDSel=0.
- lw $2,4($1) (0x8C220004) -> sequence 0,1,2,3,4; IorD=1 in MEM; RegDst=0, WDSel=1 in WB. sw (0xAC220004) -> MemWrite=1 exactly one cycle in MEM, then IF.
- beq $1,$2,3 (0x10220003): with zero=1 -> PCWrite=1, NPCOp=1 in EXE and back to IF after 3 cycles. With zero=0 -> PCWrite=0 in EXE. bne (0x14220003) gives the inverse.
- jal 0x40 (0x0C000010) -> 2-cycle sequence; in ID PCWrite=1, NPCOp=2, RegWrite=1, RegDst=2, WDSel=2. jr $31 (0x03E00008) -> NPCOp=3 in ID.
- Reset and illegal handling:
  - rstn pulsed low during MEM of sw -> MemWrite falls without a clock edge and state=0.
  - opcode 0x3F with MC_CTRL_ILLEGAL_TRAP_EN -> state=5, illegal held at 1, no further PCWrite.
  - opcode 0x3F without the macro -> one-cycle illegal pulse, and the next instruction is fetched.
